id_alu_decode_stage: RTL and testbench

//  Decode pipeline stage that produces the 13-bit one-hot ALU op vector and both ALU operands

---
 rtl/id_alu_decode_stage_pkg.sv | 57 +++++
 rtl/id_alu_decode_stage_if.sv | 48 ++++
 rtl/id_alu_decode_stage_decoder_6_64.sv | 14 +
 rtl/id_alu_decode_stage.sv | 158 +++++++++++++++
 tb/tb_id_alu_decode_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_alu_decode_stage_pkg.sv
// ============================================================================
// id_alu_decode_stage_pkg : MIPS opcode/funct codes and ALU op bit indices
// Revision 1.0
// ============================================================================
`default_nettype none

package id_alu_decode_stage_pkg;

  localparam int ALU_OP_W = 13;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;
  localparam int ALU_OV   = 12;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

endpackage

`default_nettype wire

// File: rtl/id_alu_decode_stage_if.sv
// ============================================================================
// id_alu_decode_stage_if : IF->ID handshake, register-file read and ID->EX bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface id_alu_decode_stage_if;
  logic                             fs_to_ds_valid;
  logic [31:0]                      fs_pc;
  logic [31:0]                      fs_inst;
  logic                             ds_allowin;
  logic                             es_allowin;
  logic                             ds_stall;
  logic                             ds_flush;
  logic [4:0]                       rf_raddr1;
  logic [4:0]                       rf_raddr2;
  logic [31:0]                      rf_rdata1;
  logic [31:0]                      rf_rdata2;
  logic                             ds_to_es_valid;
  logic [31:0]                      ds_pc;
  id_alu_decode_stage_pkg::alu_op_t ds_alu_op;
  logic [31:0]                      ds_alu_src1;
  logic [31:0]                      ds_alu_src2;
  logic [31:0]                      ds_store_data;
  logic [4:0]                       ds_dest;
  logic                             ds_gr_we;
  logic                             ds_mem_re;
  logic                             ds_mem_we;
  logic                             ds_illegal;

  modport master (
    input  fs_to_ds_valid, fs_pc, fs_inst, es_allowin, ds_stall, ds_flush,
           rf_rdata1, rf_rdata2,
    output ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid, ds_pc, ds_alu_op,
           ds_alu_src1, ds_alu_src2, ds_store_data, ds_dest, ds_gr_we,
           ds_mem_re, ds_mem_we, ds_illegal
  );

  modport slave (
    output fs_to_ds_valid, fs_pc, fs_inst, es_allowin, ds_stall, ds_flush,
           rf_rdata1, rf_rdata2,
    input  ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid, ds_pc, ds_alu_op,
           ds_alu_src1, ds_alu_src2, ds_store_data, ds_dest, ds_gr_we,
           ds_mem_re, ds_mem_we, ds_illegal
  );
endinterface

`default_nettype wire

// File: rtl/id_alu_decode_stage_decoder_6_64.sv
// ============================================================================
// decoder_6_64 : 6-bit binary to 64-bit one-hot decoder
// Revision 1.0
// ============================================================================
`default_nettype none

module decoder_6_64 (
  input  logic [5:0]  in_i,
  output logic [63:0] out_o
);
  assign out_o = 64'd1 << in_i;
endmodule

`default_nettype wire

// File: rtl/id_alu_decode_stage.sv
// ============================================================================
// id_alu_decode_stage : MIPS decode stage producing one-hot ALU op and operands
// Revision 1.0
// ============================================================================
`default_nettype none

module id_alu_decode_stage
  import id_alu_decode_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  id_alu_decode_stage_if.master ds_if
);

  logic        ds_valid_q, ds_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        w_ready_go, w_allowin;

  always_comb begin
    w_ready_go = ~ds_if.ds_stall;
    w_allowin  = ~ds_valid_q | (w_ready_go & ds_if.es_allowin);
    ds_valid_d = ds_valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    if (ds_if.ds_flush)
      ds_valid_d = 1'b0;
    else if (w_allowin)
      ds_valid_d = ds_if.fs_to_ds_valid;
    if (ds_if.fs_to_ds_valid & w_allowin & ~ds_if.ds_flush) begin
      pc_d   = ds_if.fs_pc;
      inst_d = ds_if.fs_inst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      pc_q       <= PC_RESET;
      inst_q     <= 32'd0;
    end else begin
      ds_valid_q <= ds_valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  assign ds_if.ds_allowin     = w_allowin;
  assign ds_if.ds_to_es_valid = ds_valid_q & w_ready_go & ~ds_if.ds_flush;
  assign ds_if.ds_pc          = ds_valid_q ? pc_q : PC_RESET;

  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_sa;
  logic [15:0] w_imm;
  logic [63:0] w_op_dec, w_fn_dec;
  logic        w_unused_dec;

  assign {w_opcode, w_rs, w_rt, w_rd, w_sa, w_funct} = inst_q;
  assign w_imm = inst_q[15:0];

  decoder_6_64 u_dec_opcode (.in_i(w_opcode), .out_o(w_op_dec));
  decoder_6_64 u_dec_funct  (.in_i(w_funct),  .out_o(w_fn_dec));

  // Only a handful of decoder lines are meaningful; the rest are sunk here.
  assign w_unused_dec = &{w_op_dec, w_fn_dec};

  logic w_is_r;
  logic w_add, w_addu, w_sub, w_subu, w_slt, w_sltu, w_and, w_or, w_xor, w_nor;
  logic w_sll, w_srl, w_sra, w_sllv, w_srlv, w_srav;
  logic w_addi, w_addiu, w_slti, w_sltiu, w_andi, w_ori, w_xori, w_lui, w_lw, w_sw;

  assign w_is_r  = w_op_dec[OP_SPECIAL];
  assign w_add   = w_is_r & w_fn_dec[FN_ADD];
  assign w_addu  = w_is_r & w_fn_dec[FN_ADDU];
  assign w_sub   = w_is_r & w_fn_dec[FN_SUB];
  assign w_subu  = w_is_r & w_fn_dec[FN_SUBU];
  assign w_slt   = w_is_r & w_fn_dec[FN_SLT];
  assign w_sltu  = w_is_r & w_fn_dec[FN_SLTU];
  assign w_and   = w_is_r & w_fn_dec[FN_AND];
  assign w_or    = w_is_r & w_fn_dec[FN_OR];
  assign w_xor   = w_is_r & w_fn_dec[FN_XOR];
  assign w_nor   = w_is_r & w_fn_dec[FN_NOR];
  assign w_sll   = w_is_r & w_fn_dec[FN_SLL];
  assign w_srl   = w_is_r & w_fn_dec[FN_SRL];
  assign w_sra   = w_is_r & w_fn_dec[FN_SRA];
  assign w_sllv  = w_is_r & w_fn_dec[FN_SLLV];
  assign w_srlv  = w_is_r & w_fn_dec[FN_SRLV];
  assign w_srav  = w_is_r & w_fn_dec[FN_SRAV];
  assign w_addi  = w_op_dec[OP_ADDI];
  assign w_addiu = w_op_dec[OP_ADDIU];
  assign w_slti  = w_op_dec[OP_SLTI];
  assign w_sltiu = w_op_dec[OP_SLTIU];
  assign w_andi  = w_op_dec[OP_ANDI];
  assign w_ori   = w_op_dec[OP_ORI];
  assign w_xori  = w_op_dec[OP_XORI];
  assign w_lui   = w_op_dec[OP_LUI];
  assign w_lw    = w_op_dec[OP_LW];
  assign w_sw    = w_op_dec[OP_SW];

  alu_op_t w_alu_op;
  logic    w_known, w_live;

  assign w_alu_op[ALU_ADD]  = w_add | w_addu | w_addi | w_addiu | w_lw | w_sw;
  assign w_alu_op[ALU_SUB]  = w_sub | w_subu;
  assign w_alu_op[ALU_SLT]  = w_slt | w_slti;
  assign w_alu_op[ALU_SLTU] = w_sltu | w_sltiu;
  assign w_alu_op[ALU_AND]  = w_and | w_andi;
  assign w_alu_op[ALU_NOR]  = w_nor;
  assign w_alu_op[ALU_OR]   = w_or | w_ori;
  assign w_alu_op[ALU_XOR]  = w_xor | w_xori;
  assign w_alu_op[ALU_SLL]  = w_sll | w_sllv;
  assign w_alu_op[ALU_SRL]  = w_srl | w_srlv;
  assign w_alu_op[ALU_SRA]  = w_sra | w_srav;
  assign w_alu_op[ALU_LUI]  = w_lui;
  assign w_alu_op[ALU_OV]   = w_add | w_sub | w_addi;

  // Every legal instruction sets at least one op bit, so an all-zero op means illegal.
  assign w_known = |w_alu_op;
  assign w_live  = ds_valid_q & w_known;

  logic [31:0] w_src1, w_src2;
  logic [4:0]  w_dest;

  always_comb begin
    w_src1 = ds_if.rf_rdata1;
    w_src2 = ds_if.rf_rdata2;
    w_dest = 5'd0;
    if (w_sll | w_srl | w_sra)
      w_src1 = {27'd0, w_sa};
    else if (w_lui)
      w_src1 = 32'd0;
    if (w_addi | w_addiu | w_slti | w_sltiu | w_lw | w_sw)
      w_src2 = {{16{w_imm[15]}}, w_imm};
    else if (w_andi | w_ori | w_xori | w_lui)
      w_src2 = {16'd0, w_imm};
    if (w_is_r)
      w_dest = w_rd;
    else if (!w_sw)
      w_dest = w_rt;
  end

  assign ds_if.rf_raddr1     = w_rs;
  assign ds_if.rf_raddr2     = w_rt;
  assign ds_if.ds_alu_op     = w_live ? w_alu_op : '0;
  assign ds_if.ds_alu_src1   = w_live ? w_src1 : 32'd0;
  assign ds_if.ds_alu_src2   = w_live ? w_src2 : 32'd0;
  assign ds_if.ds_dest       = w_live ? w_dest : 5'd0;
  assign ds_if.ds_gr_we      = w_live & ~w_sw & (w_dest != 5'd0);
  assign ds_if.ds_mem_re     = w_live & w_lw;
  assign ds_if.ds_mem_we     = w_live & w_sw;
  assign ds_if.ds_store_data = (w_live & w_sw) ? ds_if.rf_rdata2 : 32'd0;
  assign ds_if.ds_illegal    = ds_valid_q & ~w_known;

endmodule

`default_nettype wire

// File: tb/tb_id_alu_decode_stage.sv
// ============================================================================
// tb_id_alu_decode_stage : random + directed bench against a MIPS decode reference
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_id_alu_decode_stage;

  localparam logic [31:0] PC_RESET = 32'hbfc0_0000;

  typedef struct packed {
    logic [12:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        gr_we;
    logic        mem_re;
    logic        mem_we;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] regs [32];
  logic [5:0]  fn_tab [16];
  logic [5:0]  op_tab [10];

  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  id_alu_decode_stage_if bus ();

  id_alu_decode_stage #(.PC_RESET(PC_RESET)) dut (
    .clk   (clk),
    .reset (reset),
    .ds_if (bus)
  );

  assign bus.rf_rdata1 = regs[bus.rf_raddr1];
  assign bus.rf_rdata2 = regs[bus.rf_raddr2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the MIPS instruction semantics.
  function automatic exp_t ref_decode(input logic [31:0] inst);
    exp_t        e;
    logic [31:0] rs_v, rt_v, sx, zx;
    rs_v = regs[inst[25:21]];
    rt_v = regs[inst[20:16]];
    sx   = {{16{inst[15]}}, inst[15:0]};
    zx   = {16'h0000, inst[15:0]};
    e    = '0;
    if (inst[31:26] == 6'h00) begin
      e.s1   = rs_v;
      e.s2   = rt_v;
      e.dest = inst[15:11];
      case (inst[5:0])
        6'h20: e.op = 13'h1001;
        6'h21: e.op = 13'h0001;
        6'h22: e.op = 13'h1002;
        6'h23: e.op = 13'h0002;
        6'h2a: e.op = 13'h0004;
        6'h2b: e.op = 13'h0008;
        6'h24: e.op = 13'h0010;
        6'h27: e.op = 13'h0020;
        6'h25: e.op = 13'h0040;
        6'h26: e.op = 13'h0080;
        6'h00: begin e.op = 13'h0100; e.s1 = {27'd0, inst[10:6]}; end
        6'h02: begin e.op = 13'h0200; e.s1 = {27'd0, inst[10:6]}; end
        6'h03: begin e.op = 13'h0400; e.s1 = {27'd0, inst[10:6]}; end
        6'h04: e.op = 13'h0100;
        6'h06: e.op = 13'h0200;
        6'h07: e.op = 13'h0400;
        default: e.ill = 1'b1;
      endcase
    end else begin
      e.s1   = rs_v;
      e.s2   = sx;
      e.dest = inst[20:16];
      case (inst[31:26])
        6'h08: e.op = 13'h1001;
        6'h09: e.op = 13'h0001;
        6'h0a: e.op = 13'h0004;
        6'h0b: e.op = 13'h0008;
        6'h0c: begin e.op = 13'h0010; e.s2 = zx; end
        6'h0d: begin e.op = 13'h0040; e.s2 = zx; end
        6'h0e: begin e.op = 13'h0080; e.s2 = zx; end
        6'h0f: begin e.op = 13'h0800; e.s2 = zx; e.s1 = 32'd0; end
        6'h23: begin e.op = 13'h0001; e.mem_re = 1'b1; end
        6'h2b: begin e.op = 13'h0001; e.mem_we = 1'b1; e.sd = rt_v; end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) e.op = '0;
    e.gr_we = !e.ill && !e.mem_we && (e.dest != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 27);
    if (k < 16) begin
      r[31:26] = 6'h00;
      r[5:0]   = fn_tab[k];
    end else if (k < 26) begin
      r[31:26] = op_tab[k-16];
    end else if (k == 26) begin
      r[31:26] = 6'h3f;
    end else begin
      r[31:26] = 6'h00;
      r[5:0]   = 6'h3f;
    end
    return r;
  endfunction

  // One clock: drive at the falling edge, check mid-low-phase, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ea, input logic st, input logic fl);
    exp_t        e;
    logic        handoff, allow;
    logic [31:0] front;
    @(negedge clk);
    bus.fs_to_ds_valid = v;
    bus.fs_pc          = pc;
    bus.fs_inst        = inst;
    bus.es_allowin     = ea;
    bus.ds_stall       = st;
    bus.ds_flush       = fl;
    #1;
    e       = m_valid ? ref_decode(m_inst) : exp_t'('0);
    allow   = !m_valid || (!st && ea);
    handoff = m_valid && !st && !fl && ea;
    check_val("allowin", 32'(bus.ds_allowin), 32'(allow));
    check_val("to_es_valid", 32'(bus.ds_to_es_valid), 32'(m_valid && !st && !fl));
    check_val("pc", bus.ds_pc, m_valid ? m_pc : PC_RESET);
    check_val("alu_op", 32'(bus.ds_alu_op), 32'(e.op));
    check_val("illegal", 32'(bus.ds_illegal), 32'(e.ill));
    check_val("gr_we", 32'(bus.ds_gr_we), 32'(e.gr_we));
    check_val("mem_re", 32'(bus.ds_mem_re), 32'(e.mem_re));
    check_val("mem_we", 32'(bus.ds_mem_we), 32'(e.mem_we));
    if (m_valid) begin
      check_val("raddr1", 32'(bus.rf_raddr1), 32'(m_inst[25:21]));
      check_val("raddr2", 32'(bus.rf_raddr2), 32'(m_inst[20:16]));
      if (!e.ill) begin
        check_val("src1", bus.ds_alu_src1, e.s1);
        check_val("src2", bus.ds_alu_src2, e.s2);
        if (!e.mem_we) check_val("dest", 32'(bus.ds_dest), 32'(e.dest));
        else           check_val("store_data", bus.ds_store_data, e.sd);
      end
    end else begin
      check_val("src1_idle", bus.ds_alu_src1, 32'd0);
      check_val("dest_idle", 32'(bus.ds_dest), 32'd0);
    end
    if (handoff || (fl && m_valid)) begin
      front = sb.pop_front();
      if (handoff) check_val("handoff_pc", bus.ds_pc, front);
    end
    if (fl) begin
      m_valid = 1'b0;
    end else if (allow) begin
      m_valid = v;
      if (v) begin
        m_pc   = pc;
        m_inst = inst;
        sb.push_back(pc);
      end
    end
  endtask

  task automatic directed(input logic [31:0] inst, input logic [12:0] op,
                          input logic [31:0] s1, input logic [31:0] s2);
    cycle(1'b1, 32'h8000_1000, inst, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("dir_op", 32'(bus.ds_alu_op), 32'(op));
    check_val("dir_src1", bus.ds_alu_src1, s1);
    check_val("dir_src2", bus.ds_alu_src2, s2);
  endtask

  initial begin
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2a, 6'h2b, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    op_tab = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    m_valid = 1'b0;
    m_pc    = 32'd0;
    m_inst  = 32'd0;
    reset   = 1'b1;
    bus.fs_to_ds_valid = 1'b0;
    bus.fs_pc          = 32'd0;
    bus.fs_inst        = 32'd0;
    bus.es_allowin     = 1'b0;
    bus.ds_stall       = 1'b0;
    bus.ds_flush       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_to_es_valid", 32'(bus.ds_to_es_valid), 32'd0);
    check_val("rst_pc", bus.ds_pc, PC_RESET);
    check_val("rst_alu_op", 32'(bus.ds_alu_op), 32'd0);
    check_val("rst_allowin", 32'(bus.ds_allowin), 32'd1);
    reset = 1'b0;

    // ADD $3,$1,$2 / ADDIU $4,$0,-1 / ORI $5,$1,0x8000 / SRA $2,$3,4 / LUI $5,0x1234
    directed({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 13'h1001, 32'd5, 32'd7);
    check_val("add_dest", 32'(bus.ds_dest), 32'd3);
    check_val("add_gr_we", 32'(bus.ds_gr_we), 32'd1);
    directed({6'h09, 5'd0, 5'd4, 16'hffff}, 13'h0001, 32'd0, 32'hffff_ffff);
    directed({6'h0d, 5'd1, 5'd5, 16'h8000}, 13'h0040, 32'd5, 32'h0000_8000);
    directed({6'h00, 5'd0, 5'd3, 5'd2, 5'd4, 6'h03}, 13'h0400, 32'd4, regs[3]);
    directed({6'h0f, 5'd0, 5'd5, 16'h1234}, 13'h0800, 32'd0, 32'h0000_1234);

    // EX back-pressure: held instruction must survive new offers.
    cycle(1'b1, 32'h8000_2000, {6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h25}, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h8000_3000 + 32'(i * 4), 32'(rand_inst()), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_4000, {6'h23, 5'd1, 5'd7, 16'h0010}, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("lw_mem_re", 32'(bus.ds_mem_re), 32'd1);

    // Flush beats a simultaneous offer, then an illegal opcode.
    cycle(1'b1, 32'h8000_5000, 32'(rand_inst()), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("flush_valid", 32'(bus.ds_to_es_valid), 32'd0);
    cycle(1'b1, 32'h8000_6000, {6'h3f, 5'd1, 5'd9, 16'h0000}, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("ill_flag", 32'(bus.ds_illegal), 32'd1);
    check_val("ill_gr_we", 32'(bus.ds_gr_we), 32'd0);

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) < 7, $urandom & 32'hffff_fffc, rand_inst(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
      if (n == 200) begin
        // Asynchronous reset in the low phase while an instruction is held.
        cycle(1'b1, 32'h8000_7000, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b1, 1'b0, 1'b0);
        bus.fs_to_ds_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_val("arst_to_es_valid", 32'(bus.ds_to_es_valid), 32'd0);
        check_val("arst_pc", bus.ds_pc, PC_RESET);
        check_val("arst_alu_op", 32'(bus.ds_alu_op), 32'd0);
        check_val("arst_gr_we", 32'(bus.ds_gr_we), 32'd0);
        #1 reset = 1'b0;
        m_valid = 1'b0;
        sb.delete();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
